// File: rtl/sdu_seq_ctrl_pkg.sv
// Shared definitions for the pulse-sequence controller: state encoding and
// the default counter width.
package sdu_seq_ctrl_pkg;

   localparam int unsigned CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TX     = 2'd1,
      LISTEN = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/sdu_dcount.sv
// Loadable down-counter with a zero flag. The count saturates at zero, so it
// can never wrap.
module sdu_dcount #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign zero = (r_cnt == '0);

endmodule

// File: rtl/sdu_seq_ctrl.sv
// Pulse-sequence controller: plays TX for seq_len cycles, opens a listen
// window, repeats num_reps times, then issues a one-cycle done strobe.
module sdu_seq_ctrl
   import sdu_seq_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] seq_len,
   input  logic [CNT_W-1:0] listen_len,
   input  logic [CNT_W-1:0] num_reps,
   output logic             sdu_tx_en,
   output logic             rx_win,
   output logic             sdu_seq_done_strobe,
   output logic             busy,
   output logic [CNT_W-1:0] rep_idx,
   output logic             aborted,
   output logic             cfg_err
);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_seq_len, w_seq_len_nxt;
   logic [CNT_W-1:0] r_listen_len, w_listen_len_nxt;
   logic [CNT_W-1:0] r_num_reps, w_num_reps_nxt;
   logic [CNT_W-1:0] r_rep_idx, w_rep_idx_nxt;
   logic             r_aborted, w_aborted_nxt;
   logic             r_cfg_err, w_cfg_err_nxt;
   logic             r_tx_en, r_rx_win, r_strobe, r_busy;

   logic             w_load, w_dec, w_zero;
   logic [CNT_W-1:0] w_load_val;
   logic [CNT_W-1:0] w_listen_load;

   // Phase counter holds remaining cycles minus one; zero marks the last cycle.
   sdu_dcount #(.W(CNT_W)) u_phase_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (w_load),
      .dec      (w_dec),
      .load_val (w_load_val),
      .zero     (w_zero)
   );

   // A zero listen length still yields one window cycle so replay rewinds.
   assign w_listen_load = (r_listen_len == '0) ? '0 : (r_listen_len - CNT_W'(1));

   always_comb begin
      w_state_nxt      = r_state;
      w_seq_len_nxt    = r_seq_len;
      w_listen_len_nxt = r_listen_len;
      w_num_reps_nxt   = r_num_reps;
      w_rep_idx_nxt    = r_rep_idx;
      w_aborted_nxt    = r_aborted;
      w_cfg_err_nxt    = r_cfg_err;
      w_load           = 1'b0;
      w_dec            = 1'b0;
      w_load_val       = '0;

      if ((r_state != IDLE) && abort) begin
         w_state_nxt   = IDLE;
         w_aborted_nxt = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (start && !abort) begin
                  w_aborted_nxt = 1'b0;
                  w_rep_idx_nxt = '0;
                  if ((seq_len != '0) && (num_reps != '0)) begin
                     w_seq_len_nxt    = seq_len;
                     w_listen_len_nxt = listen_len;
                     w_num_reps_nxt   = num_reps;
                     w_cfg_err_nxt    = 1'b0;
                     w_load           = 1'b1;
                     w_load_val       = seq_len - CNT_W'(1);
                     w_state_nxt      = TX;
                  end else begin
                     w_cfg_err_nxt = 1'b1;
                     w_state_nxt   = DONE;
                  end
               end
            end
            TX: begin
               if (w_zero) begin
                  w_load      = 1'b1;
                  w_load_val  = w_listen_load;
                  w_state_nxt = LISTEN;
               end else begin
                  w_dec = 1'b1;
               end
            end
            LISTEN: begin
               if (w_zero) begin
                  if (r_rep_idx == (r_num_reps - CNT_W'(1))) begin
                     w_state_nxt = DONE;
                  end else begin
                     w_rep_idx_nxt = r_rep_idx + CNT_W'(1);
                     w_load        = 1'b1;
                     w_load_val    = r_seq_len - CNT_W'(1);
                     w_state_nxt   = TX;
                  end
               end else begin
                  w_dec = 1'b1;
               end
            end
            DONE: begin
               w_state_nxt = IDLE;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state and registered, so each is a flop.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_seq_len    <= '0;
         r_listen_len <= '0;
         r_num_reps   <= '0;
         r_rep_idx    <= '0;
         r_aborted    <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_tx_en      <= 1'b0;
         r_rx_win     <= 1'b0;
         r_strobe     <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_seq_len    <= w_seq_len_nxt;
         r_listen_len <= w_listen_len_nxt;
         r_num_reps   <= w_num_reps_nxt;
         r_rep_idx    <= w_rep_idx_nxt;
         r_aborted    <= w_aborted_nxt;
         r_cfg_err    <= w_cfg_err_nxt;
         r_tx_en      <= (w_state_nxt == TX);
         r_rx_win     <= (w_state_nxt == LISTEN);
         r_strobe     <= (w_state_nxt == DONE);
         r_busy       <= (w_state_nxt != IDLE);
      end
   end

   assign sdu_tx_en           = r_tx_en;
   assign rx_win              = r_rx_win;
   assign sdu_seq_done_strobe = r_strobe;
   assign busy                = r_busy;
   assign rep_idx             = r_rep_idx;
   assign aborted             = r_aborted;
   assign cfg_err             = r_cfg_err;

endmodule
